// File: rtl/quad_paddle_decoder.sv
// Quadrature paddle decoder: synchronises and glitch-filters the encoder lines,
// decodes Gray-code steps into a saturating position and keeps a per-frame snapshot.

module quad_glitch_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic prime,
  input  logic din,
  output logic filt
);

  localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

  logic [7:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (prime) begin
      cnt  <= '0;
      filt <= din;
    end else if (din == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      filt <= din;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

module quad_paddle_decoder #(
  parameter int FILTER_LEN = 4,
  parameter int POS_W      = 9,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 511,
  parameter int POS_RESET  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             quadA,
  input  logic             quadB,
  input  logic             frame_tick,
  input  logic             clear_err,
  output logic [POS_W-1:0] paddle_pos_live,
  output logic [POS_W-1:0] paddle_pos,
  output logic             step_pulse,
  output logic             step_dir,
  output logic             quad_err
);

  localparam int                 PRIME_W   = 9;
  localparam logic [PRIME_W-1:0] PRIME_LEN = PRIME_W'(FILTER_LEN + 2);
  localparam logic [POS_W:0]     MAX_EXT   = (POS_W + 1)'(POS_MAX);
  localparam logic [POS_W-1:0]   MIN_POS   = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0]   MAX_POS   = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0]   RST_POS   = POS_W'(POS_RESET);

  // Channel vectors: bit 1 = A, bit 0 = B.
  logic [1:0]         s1;
  logic [1:0]         s2;
  logic [1:0]         filt;
  logic [1:0]         prev;
  logic [PRIME_W-1:0] primeCnt;
  logic               priming;
  logic               stepInc;
  logic               stepDec;
  logic               illegal;
  logic [POS_W:0]     posInc;
  logic [POS_W:0]     posDec;
  logic [POS_W-1:0]   incSat;
  logic [POS_W-1:0]   decSat;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= {quadA, quadB};
      s2 <= s1;
    end
  end

  // Priming lets the filters and prev adopt a resting non-00 encoder state silently.
  assign priming = (primeCnt != PRIME_LEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      primeCnt <= '0;
    end else if (priming) begin
      primeCnt <= primeCnt + PRIME_W'(1);
    end
  end

  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) filterA (
    .clk   (clk),
    .reset (reset),
    .prime (priming),
    .din   (s2[1]),
    .filt  (filt[1])
  );

  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) filterB (
    .clk   (clk),
    .reset (reset),
    .prime (priming),
    .din   (s2[0]),
    .filt  (filt[0])
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    stepInc = 1'b0;
    stepDec = 1'b0;
    illegal = 1'b0;
    case ({prev, filt})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: stepInc = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: stepDec = 1'b1;
      4'b00_00, 4'b01_01, 4'b11_11, 4'b10_10: ;
      default:                                illegal = 1'b1;
    endcase
  end

  // One extra bit keeps +1 / -1 from wrapping before the saturation test.
  assign posInc = {1'b0, paddle_pos_live} + (POS_W + 1)'(1);
  assign posDec = {1'b0, paddle_pos_live} - (POS_W + 1)'(1);
  assign incSat = (posInc > MAX_EXT) ? MAX_POS : posInc[POS_W-1:0];
  assign decSat = (posDec[POS_W] || (paddle_pos_live == MIN_POS)) ? MIN_POS : posDec[POS_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      prev            <= 2'b00;
      step_pulse      <= 1'b0;
      step_dir        <= 1'b0;
      paddle_pos_live <= RST_POS;
    end else begin
      prev       <= filt;
      step_pulse <= !priming && (stepInc || stepDec);
      if (!priming && stepInc) begin
        step_dir        <= 1'b1;
        paddle_pos_live <= incSat;
      end else if (!priming && stepDec) begin
        step_dir        <= 1'b0;
        paddle_pos_live <= decSat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      paddle_pos <= RST_POS;
    end else if (frame_tick) begin
      paddle_pos <= paddle_pos_live;
    end
  end

  // Set has priority over clear so an error on the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      quad_err <= 1'b0;
    end else if (!priming && illegal) begin
      quad_err <= 1'b1;
    end else if (clear_err) begin
      quad_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_paddle_decoder.sv
// Randomised scoreboard bench for quad_paddle_decoder: a Gray-index encoder model
// predicts each step (cycle, direction, position); a negedge monitor checks them.

module tb_quad_paddle_decoder;

  localparam int FL        = 4;
  localparam int POS_W     = 9;
  localparam int POS_MIN   = 0;
  localparam int POS_MAX   = 511;
  localparam int POS_RESET = 100;
  // Drive at negedge K -> first sampling edge K+1 -> step visible after edge K+1+FL+2.
  localparam int LAT       = FL + 3;

  typedef struct {
    int cyc;
    bit dir;
    int pos;
  } step_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             quadA;
  logic             quadB;
  logic             frame_tick;
  logic             clear_err;
  logic [POS_W-1:0] paddle_pos_live;
  logic [POS_W-1:0] paddle_pos;
  logic             step_pulse;
  logic             step_dir;
  logic             quad_err;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    modelPos;
  int    expFrame;
  bit    errFlag;
  step_t expQ [$];

  logic [1:0] grayCode [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  quad_paddle_decoder #(
    .FILTER_LEN (FL),
    .POS_W      (POS_W),
    .POS_MIN    (POS_MIN),
    .POS_MAX    (POS_MAX),
    .POS_RESET  (POS_RESET)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .quadA           (quadA),
    .quadB           (quadB),
    .frame_tick      (frame_tick),
    .clear_err       (clear_err),
    .paddle_pos_live (paddle_pos_live),
    .paddle_pos      (paddle_pos),
    .step_pulse      (step_pulse),
    .step_dir        (step_dir),
    .quad_err        (quad_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int grayIdx(input logic [1:0] v);
    for (int i = 0; i < 4; i++) if (grayCode[i] == v) return i;
    return 0;
  endfunction

  function automatic logic [1:0] nextLvl(input bit fwd);
    return grayCode[(grayIdx({quadA, quadB}) + (fwd ? 1 : 3)) % 4];
  endfunction

  // Monitor: every pulse must match the oldest predicted step.
  always @(negedge clk) begin
    step_t e;
    if (!reset && step_pulse) begin
      if (expQ.size() == 0) begin
        check("unexpected_step", 1, 0);
      end else begin
        e = expQ.pop_front();
        check("step_cycle", cyc, e.cyc);
        check("step_dir", int'(step_dir), int'(e.dir));
        check("step_pos", int'(paddle_pos_live), e.pos);
      end
    end
  end

  // Move the encoder to lvl at the next negedge and update the model.
  task automatic setLevel(input logic [1:0] lvl);
    int    d;
    step_t e;
    @(negedge clk);
    d = (grayIdx(lvl) - grayIdx({quadA, quadB}) + 4) % 4;
    quadA = lvl[1];
    quadB = lvl[0];
    if (d == 1) begin
      modelPos = (modelPos < POS_MAX) ? modelPos + 1 : POS_MAX;
    end else if (d == 3) begin
      modelPos = (modelPos > POS_MIN) ? modelPos - 1 : POS_MIN;
    end else if (d == 2) begin
      errFlag = 1'b1;
    end
    if (d == 1 || d == 3) begin
      e.cyc = cyc + LAT;
      e.dir = (d == 1);
      e.pos = modelPos;
      expQ.push_back(e);
    end
  endtask

  task automatic drive(input logic [1:0] lvl, input int hold);
    setLevel(lvl);
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic stepEnc(input bit fwd, input int hold);
    drive(nextLvl(fwd), hold);
  endtask

  task automatic glitch(input bit chA, input int len);
    @(negedge clk);
    if (chA) quadA = ~quadA; else quadB = ~quadB;
    repeat (len) @(negedge clk);
    if (chA) quadA = ~quadA; else quadB = ~quadB;
    repeat (FL + 4) @(negedge clk);
  endtask

  task automatic settle(input string tag);
    int n;
    repeat (FL + 6) @(negedge clk);
    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pending_steps"}, expQ.size(), 0);
    check({tag, "_live"}, int'(paddle_pos_live), modelPos);
    check({tag, "_frame"}, int'(paddle_pos), expFrame);
    check({tag, "_err"}, int'(quad_err), int'(errFlag));
  endtask

  task automatic moveTo(input int target);
    while (modelPos != target) stepEnc(modelPos < target, FL + 2);
  endtask

  task automatic doReset(input logic [1:0] lvl);
    @(negedge clk);
    reset = 1'b1;
    quadA = lvl[1];
    quadB = lvl[0];
    repeat (3) @(negedge clk);
    check("rst_live", int'(paddle_pos_live), POS_RESET);
    check("rst_frame", int'(paddle_pos), POS_RESET);
    check("rst_pulse", int'(step_pulse), 0);
    check("rst_dir", int'(step_dir), 0);
    check("rst_err", int'(quad_err), 0);
    expQ.delete();
    modelPos = POS_RESET;
    expFrame = POS_RESET;
    errFlag  = 1'b0;
    reset    = 1'b0;
    repeat (FL + 8) @(negedge clk);
    check("prime_live", int'(paddle_pos_live), POS_RESET);
    check("prime_err", int'(quad_err), 0);
    check("prime_pulse", int'(step_pulse), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    reset      = 1'b1;
    quadA      = 1'b1;
    quadB      = 1'b1;
    frame_tick = 1'b0;
    clear_err  = 1'b0;
    modelPos   = POS_RESET;
    expFrame   = POS_RESET;
    errFlag    = 1'b0;

    // Encoder resting at 11 through reset and priming: no step, no error.
    doReset(2'b11);
    settle("rest11");

    // A change still in the filter when reset hits must vanish.
    @(negedge clk);
    quadB = 1'b0;
    repeat (3) @(negedge clk);
    doReset(2'b00);
    settle("midreset");

    // Forward sequence, 20 cycles per level.
    drive(2'b01, 20);
    drive(2'b11, 20);
    drive(2'b10, 20);
    drive(2'b00, 20);
    settle("fwdseq");
    check("fwdseq_pos", int'(paddle_pos_live), POS_RESET + 4);
    check("fwdseq_dir", int'(step_dir), 1);

    // Glitches shorter than FL are swallowed; an FL-long pulse is two real steps.
    for (int len = 1; len < FL; len++) glitch(1'b1, len);
    glitch(1'b0, FL - 1);
    settle("shortglitch");
    drive({~quadA, quadB}, FL);
    drive({~quadA, quadB}, FL + 4);
    settle("fullpulse");

    // Illegal double transition, then clear racing a second one, then a plain clear.
    drive({~quadA, ~quadB}, 10);
    settle("illegal1");
    check("illegal1_pos", int'(paddle_pos_live), POS_RESET + 4);
    setLevel({~quadA, ~quadB});
    repeat (FL + 2) @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("clear_vs_set_err", int'(quad_err), 1);
    settle("illegal2");
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    errFlag   = 1'b0;
    check("clear_err", int'(quad_err), 0);

    // Randomised walk with glitches and occasional illegal moves.
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(99, 0);
      if (r < 45)      stepEnc(1'b1, $urandom_range(FL + 8, FL + 1));
      else if (r < 80) stepEnc(1'b0, $urandom_range(FL + 8, FL + 1));
      else if (r < 93) glitch($urandom_range(1, 0) == 1, $urandom_range(FL - 1, 1));
      else             drive({~quadA, ~quadB}, $urandom_range(FL + 8, FL + 1));
      if (i % 10 == 9) settle("walk");
    end
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    errFlag   = 1'b0;
    settle("walkend");

    // Frame latch: back-to-back ticks, then a tick on the same edge as a step.
    moveTo(200);
    settle("at200");
    @(negedge clk);
    frame_tick = 1'b1;
    repeat (2) @(negedge clk);
    frame_tick = 1'b0;
    expFrame   = 200;
    check("frame_b2b", int'(paddle_pos), 200);
    setLevel(nextLvl(1'b1));
    repeat (FL + 2) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check("frame_same_edge", int'(paddle_pos), 200);
    check("frame_same_edge_live", int'(paddle_pos_live), 201);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    expFrame   = 201;
    check("frame_next", int'(paddle_pos), 201);
    settle("frame");

    // Upper saturation, then back down.
    moveTo(510);
    for (int i = 0; i < 3; i++) stepEnc(1'b1, FL + 2);
    settle("satmax");
    check("satmax_pos", int'(paddle_pos_live), POS_MAX);
    for (int i = 0; i < 2; i++) stepEnc(1'b0, FL + 2);
    settle("frommax");
    check("frommax_pos", int'(paddle_pos_live), POS_MAX - 2);
    check("frommax_dir", int'(step_dir), 0);

    // Lower saturation from a fresh reset.
    doReset({quadA, quadB});
    moveTo(POS_MIN + 1);
    for (int i = 0; i < 3; i++) stepEnc(1'b0, FL + 2);
    settle("satmin");
    check("satmin_pos", int'(paddle_pos_live), POS_MIN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
